// File: rtl/vchip8_input_pio_if.sv
// Avalon-MM slave bus bundle for the vChip8 input PIO.
// Master drives the request side; slave returns registered read data.
interface vchip8_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/vchip8_input_pio.sv
// Debounced input port with edge capture, maskable level irq and a
// one-cycle registered Avalon-MM read path.
module vchip8_input_pio #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vchip8_input_pio_if.slave      bus,
    input  logic [WIDTH-1:0]       in_port_i,
    output logic                   irq_o
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [WIDTH-1:0]                  rise, fall, cap_set, cap_clr;
    logic [31:0]                       rdata_d;
    logic                              wr_en;
    logic                              unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    // Upper writedata bits are deliberately ignored when WIDTH < 32.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_out[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                stable_d[i] = sync_out[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        cap_set = '0;
        if (EDGE_TYPE == 0) begin
            cap_set = rise;
        end else if (EDGE_TYPE == 1) begin
            cap_set = fall;
        end else begin
            cap_set = rise | fall;
        end
    end

    always_comb begin
        cap_clr = '0;
        mask_d  = mask_q;
        if (wr_en && bus.address == 2'd3) begin
            cap_clr = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == 2'd2) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
    end

    // Set is OR'd in after the clear so a same-cycle capture survives.
    assign edgecap_d = (edgecap_q & ~cap_clr) | cap_set;

    always_comb begin
        rdata_d = '0;
        case (bus.address)
            2'd0:    rdata_d = 32'(stable_q);
            2'd2:    rdata_d = 32'(mask_q);
            2'd3:    rdata_d = 32'(edgecap_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            stable_q     <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            edgecap_q    <= '0;
            bus.readdata <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], in_port_i};
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            edgecap_q    <= edgecap_d;
            bus.readdata <= rdata_d;
        end
    end

    assign irq_o = |(edgecap_q & mask_q);
endmodule

// File: tb/tb_vchip8_input_pio.sv
// Scoreboard bench: reads push expected readdata, a negedge monitor pops and
// compares one cycle later. dut1/dut2 cover falling and any-edge capture.
module tb_vchip8_input_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_port = '0;
    logic [15:0] in_port_b = '0;
    logic [1:0]  address = '0;
    logic [2:0]  cs = '0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        irq0, irq1, irq2;

    logic        rd_req = 1'b0;
    int          rd_sel = 0;
    logic        rd_pend = 1'b0;
    int          rd_sel_q = 0;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vchip8_input_pio_if bus0 ();
    vchip8_input_pio_if bus1 ();
    vchip8_input_pio_if bus2 ();

    assign bus0.address = address;
    assign bus1.address = address;
    assign bus2.address = address;
    assign bus0.writedata = writedata;
    assign bus1.writedata = writedata;
    assign bus2.writedata = writedata;
    assign bus0.write_n = write_n;
    assign bus1.write_n = write_n;
    assign bus2.write_n = write_n;
    assign bus0.chipselect = cs[0];
    assign bus1.chipselect = cs[1];
    assign bus2.chipselect = cs[2];

    vchip8_input_pio #(.EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port_i(in_port), .irq_o(irq0)
    );
    vchip8_input_pio #(.EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port_i(in_port_b), .irq_o(irq1)
    );
    vchip8_input_pio #(.EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port_i(in_port_b), .irq_o(irq2)
    );

    always @(posedge clk) begin
        rd_pend  <= rd_req;
        rd_sel_q <= rd_sel;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            logic [31:0] got;
            exp_t        e;
            case (rd_sel_q)
                0:       got = bus0.readdata;
                1:       got = bus1.readdata;
                default: got = bus2.readdata;
            endcase
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read got=%08h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.exp) begin
                    bad++;
                    $display("FAIL %s dut%0d got=%08h required=%08h", e.name, e.sel, got, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp,
                      input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
        address = addr;
        rd_sel  = sel;
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [1:0] addr, input logic [31:0] data);
        address     = addr;
        writedata   = data;
        cs[sel]     = 1'b1;
        write_n     = 1'b0;
        tick();
        cs          = '0;
        write_n     = 1'b1;
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b required=%0b", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ticks(3);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(0, 2'(a), 32'h0, "reset_read");
        chk("reset_irq", irq0, 1'b0);

        // Debounce latency: visible on readdata after edge 7, not before.
        in_port = 16'h0001;
        for (int k = 1; k <= 7; k++) rd(0, 2'd0, (k == 7) ? 32'h1 : 32'h0, "debounce_latency");
        rd(0, 2'd3, 32'h1, "rise_capture");
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h0, "edgecap_clear");

        // Glitch on bit 3 shorter than the debounce window.
        in_port = 16'h0009;
        ticks(3);
        in_port = 16'h0001;
        ticks(10);
        rd(0, 2'd0, 32'h1, "glitch_data");
        rd(0, 2'd3, 32'h0, "glitch_edgecap");

        // Falling edge in rising mode is not captured.
        in_port = 16'h0000;
        ticks(10);
        rd(0, 2'd0, 32'h0, "fall_data");
        rd(0, 2'd3, 32'h0, "fall_no_capture");

        wr(0, 2'd2, 32'h1);
        rd(0, 2'd2, 32'h1, "irqmask_read");
        in_port = 16'h0001;
        ticks(5);
        chk("irq_before_edge6", irq0, 1'b0);
        tick();
        chk("irq_at_edge6", irq0, 1'b1);
        rd(0, 2'd3, 32'h1, "capture_bit0");
        wr(0, 2'd3, 32'h1);
        chk("irq_after_clear", irq0, 1'b0);
        rd(0, 2'd3, 32'h0, "edgecap_after_clear");

        in_port = 16'h0003;
        ticks(8);
        rd(0, 2'd3, 32'h2, "unmasked_capture");
        chk("unmasked_irq", irq0, 1'b0);
        wr(0, 2'd3, 32'h2);

        // Clear write lands on the same edge that bit 2 is captured.
        in_port = 16'h0007;
        ticks(5);
        wr(0, 2'd3, 32'h4);
        rd(0, 2'd3, 32'h4, "set_wins_collision");

        wr(0, 2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2, 32'h0000_FFFF, "mask_upper_zero");
        wr(0, 2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "reserved_reads_zero");
        chk("irq_masked_bit2", irq0, 1'b1);

        // Asynchronous mid-run reset with inputs held high.
        reset_n = 1'b0;
        #1;
        chk("async_reset_irq", irq0, 1'b0);
        ticks(2);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(0, 2'(a), 32'h0, "midrun_reset_read");
        ticks(10);
        rd(0, 2'd0, 32'h7, "post_reset_data");
        rd(0, 2'd3, 32'h7, "post_reset_rise");
        chk("post_reset_irq", irq0, 1'b0);

        in_port_b = 16'h00FF;
        ticks(10);
        rd(1, 2'd0, 32'h00FF, "fallmode_data");
        rd(1, 2'd3, 32'h0, "fallmode_no_rise");
        rd(2, 2'd3, 32'h00FF, "anymode_rise");
        wr(2, 2'd3, 32'h00FF);
        rd(2, 2'd3, 32'h0, "anymode_clear");
        in_port_b = 16'h0000;
        ticks(10);
        rd(1, 2'd3, 32'h00FF, "fallmode_fall");
        rd(2, 2'd3, 32'h00FF, "anymode_fall");
        chk("edge_mode_irq_masked", irq1 | irq2, 1'b0);

        ticks(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vchip8_input_pio.md
# vchip8_input_pio

Parametrised Avalon-MM input port for the vChip8 system: the successor to the fixed 16-bit switch reader. It synchronises and debounces a WIDTH-bit bank of external inputs (switches, keypad lines) and latches selected edges into a write-one-to-clear capture register. It raises a maskable level interrupt to the Nios II. Readback uses a one-cycle registered read path, zero-extended to 32 bits.

## Interface
- WIDTH, 16: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, >=2.
- DEBOUNCE_CYCLES, 4: consecutive cycles of difference required before the debounced value changes, >=1.
- EDGE_TYPE, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.

- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - 0 DATA: read-only debounced value.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK: read/write, WIDTH bits.
  - 3 EDGECAP: read; writing 1 to a bit clears that bit.
- Register bits above WIDTH read 0.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. sync_out is the last stage.
- Debounce, per bit:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync_out == stable, the counter clears to 0.
  - If sync_out != stable and counter == DEBOUNCE_CYCLES-1, then stable <= sync_out and the counter clears.
  - Otherwise, the counter increments.
  - A difference that disappears before the threshold is discarded.
- Edge capture: EDGECAP[i] is set in the same cycle that stable[i] updates, when the transition matches EDGE_TYPE.
- EDGECAP write: chipselect & !write_n & address==3 clears EDGECAP[i] where writedata[i]=1.
- Simultaneous set and clear on the same bit: set wins.
- IRQMASK write: chipselect & !write_n & address==2 loads writedata[WIDTH-1:0].
- irq = |(EDGECAP & IRQMASK), combinational from registers with no extra latency.
- Read path: readdata <= zero-extended register selected by address, on every clk edge.
  - Reads are side-effect free.
  - chipselect is not required for reads.
- Reset:
  - Synchroniser flops, stable, counters, IRQMASK, EDGECAP and readdata all go to 0, so irq=0.
  - Inputs held at 1 through reset produce a rising edge after debounce once reset is released. This is intended.
  - Asserting reset mid-debounce discards the pending change.

## Timing
- Edge numbering: in_port changes before edge 0 and is held; edge 1 is the first edge after the change.
- sync_out reflects the new value after edge SYNC_STAGES.
- stable and EDGECAP update at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- irq asserts in the same cycle as the EDGECAP update.
- DATA and EDGECAP are visible on readdata one edge later.
- Register writes take effect at the write edge. Readback of a written value appears one edge after the write.
- Read-to-readdata latency is 1 cycle. The bus master uses readLatency=1 with no waitrequest.
- Debounce of each bit is independent. Multiple bits may update in the same cycle.

## Test plan
Defaults apply: WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0.
- Reset values: assert reset_n=0 mid-run, then read all four addresses -> readdata 0x00000000 for each; irq=0.
- Debounce latency: in_port 0x0000->0x0001 held, address=0 -> stable at edge 6; readdata=0x00000001 after edge 7, not before.
- Glitch rejection: in_port bit 3 high for 3 cycles, then low -> DATA stays 0x0000; EDGECAP stays 0.
- Capture and interrupt:
  - Write IRQMASK=0x0001, then drive in_port bit 0 rising -> EDGECAP=0x0001 and irq=1 at edge 6.
  - Write 0x1 to address 3 -> EDGECAP=0 and irq=0 one edge later.
  - An unmasked bit 1 rising edge sets EDGECAP bit 1 with irq remaining 0.
- Set/clear collision: EDGECAP bit 2 sets on the same edge as a clear write to bit 2 -> bit 2 remains 1.
- Edge modes: EDGE_TYPE=1, in_port 0x0000->0x00FF->0x0000 -> no capture on the rise; EDGECAP=0x00FF after the fall. With EDGE_TYPE=2 both transitions capture.
